// File: rtl/led_game_pkg.sv
// Shared constants for the LED pattern generator: pattern select codes and
// head-travel directions.
package led_game_pkg;

    localparam logic [1:0] MODE_BOUNCE = 2'd0;
    localparam logic [1:0] MODE_ROTATE = 2'd1;
    localparam logic [1:0] MODE_FILL   = 2'd2;
    localparam logic [1:0] MODE_COMET  = 2'd3;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage : led_game_pkg

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter producing a one-cycle terminal-count tick.
// enable freezes the count; clear restarts it and suppresses the tick.
module tick_prescaler #(
    parameter int TICK_DIV = 12500000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int                CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = enable && !clear && (cnt_q == LAST);

    // NOTE: cnt_d is defaulted first so no path through this block leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its next value from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : tick_prescaler

// File: rtl/led_pattern_gen.sv
// Runtime-selectable LED bar pattern generator (bounce, rotate, fill, comet)
// advancing one head position per prescaled tick; outputs are registered.
module led_pattern_gen
    import led_game_pkg::*;
#(
    parameter  int N_LEDS   = 8,
    parameter  int TICK_DIV = 12500000,
    localparam int POS_W    = $clog2(N_LEDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] leds,
    output logic [POS_W-1:0]  pos,
    output logic              step
);

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);

    logic [1:0]        mode_q, mode_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [POS_W-1:0]  prev_pos_q, prev_pos_d;
    logic              dir_q, dir_d;
    logic [N_LEDS-1:0] leds_q, leds_d;
    logic              step_q;
    logic              restart;
    logic              tick;

    assign restart = (mode != mode_q);

    // A pattern switch also restarts the prescaler so the new pattern gets a
    // full first step.
    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (restart),
        .tick   (tick)
    );

    always_comb begin
        mode_d     = mode_q;
        pos_d      = pos_q;
        prev_pos_d = prev_pos_q;
        dir_d      = dir_q;
        if (restart) begin
            mode_d     = mode;
            pos_d      = POS_MAX;
            prev_pos_d = POS_MAX;
            dir_d      = DIR_DOWN;
        end else if (tick) begin
            prev_pos_d = pos_q;
            if (mode_q == MODE_ROTATE) begin
                dir_d = DIR_DOWN;
                pos_d = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
            end else if (dir_q == DIR_DOWN) begin
                // Turn around at the end in the same step, so the end LED
                // is shown for exactly one step.
                if (pos_q == '0) begin
                    dir_d = DIR_UP;
                    pos_d = POS_W'(1);
                end else begin
                    pos_d = pos_q - 1'b1;
                end
            end else begin
                if (pos_q == POS_MAX) begin
                    dir_d = DIR_DOWN;
                    pos_d = POS_MAX - 1'b1;
                end else begin
                    pos_d = pos_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        leds_d = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            case (mode_q)
                MODE_FILL:  leds_d[i] = (POS_W'(i) >= pos_q);
                MODE_COMET: leds_d[i] = (POS_W'(i) == pos_q) || (POS_W'(i) == prev_pos_q);
                default:    leds_d[i] = (POS_W'(i) == pos_q);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q     <= mode;
            pos_q      <= POS_MAX;
            prev_pos_q <= POS_MAX;
            dir_q      <= DIR_DOWN;
            leds_q     <= '0;
            step_q     <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            pos_q      <= pos_d;
            prev_pos_q <= prev_pos_d;
            dir_q      <= dir_d;
            leds_q     <= leds_d;
            step_q     <= tick;
        end
    end

    assign leds = leds_q;
    assign pos  = pos_q;
    assign step = step_q;

endmodule : led_pattern_gen
